// File: rtl/mux_nway_reg.sv
// -----------------------------------------------------------------------------
// mux_nway_reg
//   Registered N-input operand multiplexer with a valid/ready output stage.
//   One of NUM WIDTH-bit operands is chosen by an explicit select (i_s) or,
//   when built with round-robin support, by an internal counter (i_mode=1).
//   The chosen operand is held in a single output register that only
//   advances when the consumer is ready, so a stalled consumer never loses
//   a selected operand.
//
//   Build option:
//     MUX_NWAY_RR_EN  defined   : round-robin counter built, i_mode honoured.
//     MUX_NWAY_RR_EN  undefined : no counter, i_mode ignored, select = i_s.
//
//   Ports:
//     i_clk        rising-edge clock
//     i_rstn       synchronous active-low reset
//     i_in         flattened operands, operand k = i_in[k*WIDTH +: WIDTH]
//     i_s          explicit select (used when i_mode=0)
//     i_mode       0 = explicit select, 1 = round-robin
//     i_in_valid   i_in / i_s / i_mode valid this cycle
//     o_in_ready   block can accept this cycle
//     o_o          registered selected operand
//     o_out_valid  o_o holds an unconsumed result
//     i_out_ready  consumer takes o_o this cycle
//     o_cur_sel    index that produced the current o_o
//     o_sel_err    current o_o came from an out-of-range select
// -----------------------------------------------------------------------------
module mux_nway_reg #(
  parameter int WIDTH = 16,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [NUM*WIDTH-1:0] i_in,
  input  logic [SEL_W-1:0]     i_s,
  input  logic                 i_mode,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [WIDTH-1:0]     o_o,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [SEL_W-1:0]     o_cur_sel,
  output logic                 o_sel_err
);

  logic [WIDTH-1:0] r_o;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_cur_sel;
  logic             r_sel_err;

  logic             w_in_ready;
  logic             w_capture;
  logic [SEL_W-1:0] w_sel;
  logic [WIDTH-1:0] w_operand;
  logic             w_sel_err;

  // Pass-through ready: the output slot frees up in the same cycle the
  // consumer takes it, which is what lets back-to-back captures run bubble-free.
  assign w_in_ready = !r_out_valid || i_out_ready;
  assign w_capture  = i_in_valid && w_in_ready;

`ifdef MUX_NWAY_RR_EN
  logic [SEL_W-1:0] r_rr_cnt;

  assign w_sel = i_mode ? r_rr_cnt : i_s;

  // Counter only moves on a round-robin capture and wraps at NUM-1, so it
  // never points at a non-existent operand.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_rr_cnt <= '0;
    end else if (w_capture && i_mode) begin
      if (r_rr_cnt == SEL_W'(NUM - 1)) begin
        r_rr_cnt <= '0;
      end else begin
        r_rr_cnt <= r_rr_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_mode;

  assign w_unused_mode = i_mode;
  assign w_sel         = i_s;
`endif

  // Compare-and-pick rather than a variable part-select so that a select
  // beyond NUM-1 yields zero instead of reading past the operand bus.
  always_comb begin
    w_operand = '0;
    for (int k = 0; k < NUM; k++) begin
      if (w_sel == SEL_W'(k)) begin
        w_operand = i_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sel_err = (32'(w_sel) >= NUM);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_o         <= '0;
      r_out_valid <= 1'b0;
      r_cur_sel   <= '0;
      r_sel_err   <= 1'b0;
    end else if (w_capture) begin
      r_o         <= w_operand;
      r_out_valid <= 1'b1;
      r_cur_sel   <= w_sel;
      r_sel_err   <= w_sel_err;
    end else if (i_out_ready) begin
      // Consumed with nothing new: data fields keep their last values.
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_o         = r_o;
  assign o_out_valid = r_out_valid;
  assign o_cur_sel   = r_cur_sel;
  assign o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_nway_reg.sv
module tb_mux_nway_reg;

  logic        clk = 1'b0;
  logic        rstn;

  // NUM=4 instance
  logic [63:0] in4;
  logic [1:0]  s4;
  logic        mode4;
  logic        in_valid4;
  logic        in_ready4;
  logic [15:0] o4;
  logic        out_valid4;
  logic        out_ready4;
  logic [1:0]  cur_sel4;
  logic        sel_err4;

  // NUM=3 instance for out-of-range selects
  logic [47:0] in3;
  logic [1:0]  s3;
  logic        mode3;
  logic        in_valid3;
  logic        in_ready3;
  logic [15:0] o3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  cur_sel3;
  logic        sel_err3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_nway_reg #(.WIDTH(16), .NUM(4), .SEL_W(2)) u_dut4 (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_in        (in4),
    .i_s         (s4),
    .i_mode      (mode4),
    .i_in_valid  (in_valid4),
    .o_in_ready  (in_ready4),
    .o_o         (o4),
    .o_out_valid (out_valid4),
    .i_out_ready (out_ready4),
    .o_cur_sel   (cur_sel4),
    .o_sel_err   (sel_err4)
  );

  mux_nway_reg #(.WIDTH(16), .NUM(3), .SEL_W(2)) u_dut3 (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_in        (in3),
    .i_s         (s3),
    .i_mode      (mode3),
    .i_in_valid  (in_valid3),
    .o_in_ready  (in_ready3),
    .o_o         (o3),
    .o_out_valid (out_valid3),
    .i_out_ready (out_ready3),
    .o_cur_sel   (cur_sel3),
    .o_sel_err   (sel_err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk_op(int k, int v);
    return {4'(k), 6'(v), 6'(63 - v)};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    in4 = '0; s4 = '0; mode4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
    in3 = '0; s3 = '0; mode3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    step();
    step();
    checks++;
    if (o4 !== 16'h0 || out_valid4 !== 1'b0 || cur_sel4 !== 2'd0 || sel_err4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: o=%h v=%b sel=%0d err=%b expected o=0000 v=0 sel=0 err=0",
               o4, out_valid4, cur_sel4, sel_err4);
    end
    checks++;
    if (in_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready4);
    end
    in_valid4 = 1'b0;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_explicit();
    in4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    mode4 = 1'b0; s4 = 2'd2; in_valid4 = 1'b1; out_ready4 = 1'b1;
    step();
    checks++;
    if (o4 !== 16'h3333 || cur_sel4 !== 2'd2 || out_valid4 !== 1'b1 || sel_err4 !== 1'b0) begin
      failures++;
      $display("FAIL explicit_s2: o=%h sel=%0d v=%b err=%b expected o=3333 sel=2 v=1 err=0",
               o4, cur_sel4, out_valid4, sel_err4);
    end
    // Back-to-back sweep: new operand every cycle with the consumer always ready.
    for (int s = 0; s < 4; s++) begin
      for (int v = 0; v < 64; v++) begin
        for (int k = 0; k < 4; k++) in4[k*16 +: 16] = mk_op(k, v);
        s4 = 2'(s);
        step();
        checks++;
        if (o4 !== mk_op(s, v) || cur_sel4 !== 2'(s) || out_valid4 !== 1'b1) begin
          failures++;
          $display("FAIL sweep s=%0d v=%0d: o=%h sel=%0d v=%b expected o=%h sel=%0d v=1",
                   s, v, o4, cur_sel4, out_valid4, mk_op(s, v), s);
        end
      end
    end
    in_valid4 = 1'b0;
    step();
    checks++;
    if (out_valid4 !== 1'b0 || o4 !== mk_op(3, 63) || cur_sel4 !== 2'd3) begin
      failures++;
      $display("FAIL consume_no_capture: v=%b o=%h sel=%0d expected v=0 o=%h sel=3",
               out_valid4, o4, cur_sel4, mk_op(3, 63));
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_o [4];
    exp_o[0] = 16'h1111; exp_o[1] = 16'h2222; exp_o[2] = 16'h3333; exp_o[3] = 16'h4444;
    in4 = {exp_o[3], exp_o[2], exp_o[1], exp_o[0]};
    mode4 = 1'b0; s4 = 2'd1; in_valid4 = 1'b1; out_ready4 = 1'b1;
    step();
    checks++;
    if (o4 !== 16'h2222 || out_valid4 !== 1'b1) begin
      failures++;
      $display("FAIL bp_capture: o=%h v=%b expected o=2222 v=1", o4, out_valid4);
    end
    out_ready4 = 1'b0; s4 = 2'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (o4 !== 16'h2222 || out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || cur_sel4 !== 2'd1) begin
        failures++;
        $display("FAIL bp_stall cycle %0d: o=%h v=%b rdy=%b sel=%0d expected o=2222 v=1 rdy=0 sel=1",
                 c, o4, out_valid4, in_ready4, cur_sel4);
      end
    end
    out_ready4 = 1'b1;
    #1;
    checks++;
    if (in_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_pass: rdy=%b expected 1", in_ready4);
    end
    step();
    checks++;
    if (o4 !== 16'h4444 || out_valid4 !== 1'b1 || cur_sel4 !== 2'd3) begin
      failures++;
      $display("FAIL bp_release: o=%h v=%b sel=%0d expected o=4444 v=1 sel=3",
               o4, out_valid4, cur_sel4);
    end
    in_valid4 = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    in3 = {16'h3333, 16'h2222, 16'h1111};
    mode3 = 1'b0; s3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
    step();
    checks++;
    if (o3 !== 16'h0000 || sel_err3 !== 1'b1 || out_valid3 !== 1'b1 || cur_sel3 !== 2'd3) begin
      failures++;
      $display("FAIL oor_s3: o=%h err=%b v=%b sel=%0d expected o=0000 err=1 v=1 sel=3",
               o3, sel_err3, out_valid3, cur_sel3);
    end
    s3 = 2'd0;
    step();
    checks++;
    if (o3 !== 16'h1111 || sel_err3 !== 1'b0 || out_valid3 !== 1'b1) begin
      failures++;
      $display("FAIL oor_clear: o=%h err=%b v=%b expected o=1111 err=0 v=1",
               o3, sel_err3, out_valid3);
    end
    s3 = 2'd2;
    step();
    checks++;
    if (o3 !== 16'h3333 || sel_err3 !== 1'b0 || cur_sel3 !== 2'd2) begin
      failures++;
      $display("FAIL oor_top_index: o=%h err=%b sel=%0d expected o=3333 err=0 sel=2",
               o3, sel_err3, cur_sel3);
    end
    in_valid3 = 1'b0;
    step();
  endtask

`ifdef MUX_NWAY_RR_EN
  task automatic test_round_robin();
    logic [1:0]  exp_sel [6];
    logic [15:0] exp_o   [6];
    exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2;
    exp_sel[3] = 2'd3; exp_sel[4] = 2'd0; exp_sel[5] = 2'd1;
    exp_o[0] = 16'h1111; exp_o[1] = 16'h2222; exp_o[2] = 16'h3333;
    exp_o[3] = 16'h4444; exp_o[4] = 16'h1111; exp_o[5] = 16'h2222;
    in4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    mode4 = 1'b1; s4 = 2'd3; in_valid4 = 1'b1; out_ready4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (cur_sel4 !== exp_sel[c] || o4 !== exp_o[c] || out_valid4 !== 1'b1) begin
        failures++;
        $display("FAIL rr_wrap cycle %0d: sel=%0d o=%h v=%b expected sel=%0d o=%h v=1",
                 c, cur_sel4, o4, out_valid4, exp_sel[c], exp_o[c]);
      end
    end
    in_valid4 = 1'b0; mode4 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_stall();
    in4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    mode4 = 1'b1; in_valid4 = 1'b1; out_ready4 = 1'b1;
    // Counter holds 2 after the wrap test; one capture uses 2 and leaves 3,
    // a second uses 3 and wraps to 0, two more leave the counter at 2.
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (cur_sel4 !== 2'd1) begin
      failures++;
      $display("FAIL rms_setup: sel=%0d expected 1", cur_sel4);
    end
    out_ready4 = 1'b0;
    step();
    checks++;
    if (out_valid4 !== 1'b1 || cur_sel4 !== 2'd1 || o4 !== 16'h2222) begin
      failures++;
      $display("FAIL rms_stall: v=%b sel=%0d o=%h expected v=1 sel=1 o=2222",
               out_valid4, cur_sel4, o4);
    end
    rstn = 1'b0;
    out_ready4 = 1'b1;
    step();
    checks++;
    if (o4 !== 16'h0 || out_valid4 !== 1'b0 || cur_sel4 !== 2'd0) begin
      failures++;
      $display("FAIL rms_reset: o=%h v=%b sel=%0d expected o=0000 v=0 sel=0",
               o4, out_valid4, cur_sel4);
    end
    rstn = 1'b1;
    step();
    checks++;
    if (cur_sel4 !== 2'd0 || o4 !== 16'h1111 || out_valid4 !== 1'b1) begin
      failures++;
      $display("FAIL rms_first_rr: sel=%0d o=%h v=%b expected sel=0 o=1111 v=1",
               cur_sel4, o4, out_valid4);
    end
    in_valid4 = 1'b0; mode4 = 1'b0;
    step();
  endtask
`else
  task automatic test_macro_off();
    in4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    mode4 = 1'b1; s4 = 2'd1; in_valid4 = 1'b1; out_ready4 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (cur_sel4 !== 2'd1 || o4 !== 16'h2222 || out_valid4 !== 1'b1) begin
        failures++;
        $display("FAIL macro_off capture %0d: sel=%0d o=%h v=%b expected sel=1 o=2222 v=1",
                 c, cur_sel4, o4, out_valid4);
      end
    end
    in_valid4 = 1'b0; mode4 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_stall();
    in4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    mode4 = 1'b0; s4 = 2'd2; in_valid4 = 1'b1; out_ready4 = 1'b1;
    step();
    out_ready4 = 1'b0;
    step();
    checks++;
    if (out_valid4 !== 1'b1 || o4 !== 16'h3333) begin
      failures++;
      $display("FAIL rms_stall: v=%b o=%h expected v=1 o=3333", out_valid4, o4);
    end
    rstn = 1'b0;
    out_ready4 = 1'b1;
    step();
    checks++;
    if (o4 !== 16'h0 || out_valid4 !== 1'b0 || cur_sel4 !== 2'd0) begin
      failures++;
      $display("FAIL rms_reset: o=%h v=%b sel=%0d expected o=0000 v=0 sel=0",
               o4, out_valid4, cur_sel4);
    end
    rstn = 1'b1;
    in_valid4 = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_explicit();
`ifdef MUX_NWAY_RR_EN
    test_round_robin();
`else
    test_macro_off();
`endif
    test_backpressure();
    test_out_of_range();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nway_reg.md
# mux_nway_reg

Parametrised, registered N-input multiplexer that succeeds the 16-bit 2-input datapath mux. It selects one of NUM WIDTH-bit operands, either by an explicit select or by an internal round-robin counter, and holds the result in an output register behind a valid/ready handshake. It sits between the register file/ALU operand sources and the next pipeline stage, where a stalled consumer must not lose a selected operand.

## Interface
- WIDTH, 16: bits per operand and output.
- NUM, 4: number of input operands, 2..16.
- SEL_W, 2: select width; ceil(log2(NUM)), minimum 1.

- CLK  input  1  rising-edge clock.
- RSTN  input  1  reset, synchronous, active-low; one clock, sync active-low reset.
- IN  input  NUM*WIDTH  flattened operands; operand k = IN[k*WIDTH +: WIDTH].
- S  input  SEL_W  explicit select, used when MODE=0.
- MODE  input  1  0 = explicit select, 1 = round-robin.
- IN_VALID  input  1  IN/S/MODE valid this cycle.
- IN_READY  output  1  block can accept this cycle.
- O  output  WIDTH  registered selected operand.
- OUT_VALID  output  1  O holds an unconsumed result.
- OUT_READY  input  1  consumer takes O this cycle.
- CUR_SEL  output  SEL_W  index that produced the current O.
- SEL_ERR  output  1  current O came from an out-of-range select.

## Operation
- Single output register stage; no internal queue beyond it.
- IN_READY = !OUT_VALID || OUT_READY (combinational, pass-through ready).
- Capture when IN_VALID && IN_READY: O <= operand[sel], CUR_SEL <= sel, SEL_ERR <= (sel >= NUM), OUT_VALID <= 1.
- sel = S when MODE=0; sel = RR counter when MODE=1.
- Out-of-range sel (>= NUM): O <= 0, SEL_ERR <= 1; the result is still delivered with OUT_VALID.
- RR counter: advances by 1 only on a capture with MODE=1; wraps NUM-1 -> 0. Holds in MODE=0 and on cycles without a capture. The counter never produces an out-of-range index.
- Consumption without capture (OUT_VALID && OUT_READY && !IN_VALID): OUT_VALID <= 0. O, CUR_SEL and SEL_ERR hold their last values.
- Simultaneous consume and capture: new data loaded, OUT_VALID stays 1 with no bubble.
- Stall (OUT_VALID && !OUT_READY): O, CUR_SEL, SEL_ERR and the counter all hold. Changes on IN and S are ignored.
- MODE change takes effect on the next capture. The counter keeps its value across MODE changes.

## Timing
- Latency: 1 cycle from the capture edge to O/OUT_VALID.
- Throughput: 1 result per cycle while OUT_READY=1.
- Reset (RSTN=0 at a rising edge): O=0, OUT_VALID=0, CUR_SEL=0, SEL_ERR=0, RR counter=0. IN_READY reads 1 after reset.
- Reset mid-operation: a pending result is discarded. Reset has priority over a capture in the same cycle.
- No combinational path from IN/S to O. IN_READY depends combinationally only on OUT_VALID and OUT_READY.

## Configuration
- MUX_NWAY_RR_EN defined: round-robin counter and MODE behaviour as above.
- MUX_NWAY_RR_EN undefined: no counter logic is built. MODE is ignored and treated as 0; sel = S always.

## Test plan
- Reset then explicit select: WIDTH=16, NUM=4, IN = {0x4444,0x3333,0x2222,0x1111}, MODE=0, S=2, IN_VALID=1, OUT_READY=1.
  - Next cycle: O=0x3333, CUR_SEL=2, OUT_VALID=1, SEL_ERR=0.
  - A full sweep of S 0..3 × 64 operand values matches the operand every cycle.
- Round-robin wrap: MODE=1, IN_VALID=1 for 6 cycles, OUT_READY=1.
  - CUR_SEL sequence is 0,1,2,3,0,1.
  - O sequence is 0x1111,0x2222,0x3333,0x4444,0x1111,0x2222.
- Backpressure: capture S=1, then OUT_READY=0 for 3 cycles while S=3.
  - O holds 0x2222 and IN_READY=0 during the stall.
  - Raise OUT_READY: O=0x4444 the next cycle with no gap in OUT_VALID.
- Out-of-range: NUM=3, SEL_W=2, S=3.
  - O=0x0000, SEL_ERR=1, OUT_VALID=1.
  - A following S=0 capture clears SEL_ERR.
- Reset mid-stall: OUT_VALID=1, OUT_READY=0, counter=2, then RSTN=0 for one edge.
  - O=0, OUT_VALID=0, CUR_SEL=0.
  - The next MODE=1 capture uses index 0.
- Macro off (MUX_NWAY_RR_EN undefined): MODE=1, S=1 for 3 captures.
  - CUR_SEL=1 and O=0x2222 on every capture.
